// File: rtl/calc_pkg.sv
// Shared op codes, FSM state encoding and segment constants for the sequential calculator.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARITH,
        S_CONV,
        S_DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // True when DIGITS decimal digits can hold every value of an rw-bit result.
    function automatic bit calc_fits(int digits, int rw);
        longint unsigned p10;
        longint unsigned maxv;
        p10  = 1;
        maxv = (longint'(1) << rw) - 1;
        for (int i = 0; i < digits && i < 19; i++) begin
            p10 = p10 * 10;
        end
        return (digits >= 19) || (p10 > maxv);
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// Hex digit to active-low 7-segment pattern, bit order gfedcba; purely combinational.
module seg7_lut (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/calc_seq.sv
// Sequential add/sub/shift-add multiply, bit-serial double-dabble to BCD, and 7-segment drive.
// Latency from accepted start to done: (1 or WIDTH) + 2*WIDTH + 1 cycles; starts outside IDLE are dropped.
module calc_seq
    import calc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iSTART,
    input  logic [1:0]            iOP,
    input  logic [WIDTH-1:0]      iOP1,
    input  logic [WIDTH-1:0]      iOP2,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic [2*WIDTH-1:0]    oRESULT,
    output logic                  oNEG,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic [7*DIGITS-1:0]   oSEG
);

    localparam int RW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(RW + 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("calc_seq: WIDTH must be in 2..16");
    end
    if (!calc_fits(DIGITS, RW)) begin : g_bad_digits
        $error("calc_seq: DIGITS too small for a 2*WIDTH-bit result");
    end

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [RW-1:0]      acc;
    logic [RW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic [RW-1:0]      bin_q;
    logic [BW-1:0]      bcd_q;

    logic [RW-1:0]      mul_nxt;
    logic [RW-1:0]      addsub_res;
    logic               addsub_neg;
    logic [BW-1:0]      bcd_adj;
    logic [BW-1:0]      bcd_nxt;
    logic [DIGITS-1:0]  lit;
    logic               lz_run;
    logic [7*DIGITS-1:0] seg_raw;
    logic [7*DIGITS-1:0] seg_nxt;

    assign mul_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        addsub_neg = 1'b0;
        addsub_res = RW'(a_q) + RW'(b_q);
        if (op_q == OP_SUB) begin
            if (a_q < b_q) begin
                addsub_res = RW'(b_q - a_q);
                addsub_neg = 1'b1;
            end else begin
                addsub_res = RW'(a_q - b_q);
            end
        end
    end

    // One double-dabble step: correct nibbles >= 5, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_nxt = {bcd_adj[BW-2:0], bin_q[RW-1]};

    always_comb begin
        lz_run = 1'b0;
        lit    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run | (bcd_nxt[4*i +: 4] != 4'd0);
            lit[i] = lz_run | (BLANK_LZ == 0) | (i == 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_lut u_lut (
            .digit (bcd_nxt[4*g +: 4]),
            .seg   (seg_raw[7*g +: 7])
        );
    end

    always_comb begin
        seg_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_nxt[7*i +: 7] = lit[i] ? seg_raw[7*i +: 7] : SEG_BLANK;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
            oRESULT <= '0;
            oNEG    <= 1'b0;
            oBCD    <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                oSEG[7*i +: 7] <= (i == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_BLANK;
            end
        end else begin
            oDONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iSTART) begin
                        op_q   <= iOP;
                        a_q    <= iOP1;
                        b_q    <= iOP2;
                        acc    <= '0;
                        mcand  <= RW'(iOP1);
                        mplier <= iOP2;
                        cnt    <= '0;
                        oBUSY  <= 1'b1;
                        state  <= S_ARITH;
                    end
                end
                S_ARITH: begin
                    if (op_q == OP_MUL) begin
                        acc    <= mul_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            bin_q <= mul_nxt;
                            neg_q <= 1'b0;
                            bcd_q <= '0;
                            cnt   <= '0;
                            state <= S_CONV;
                        end
                    end else begin
                        acc   <= addsub_res;
                        bin_q <= addsub_res;
                        neg_q <= addsub_neg;
                        bcd_q <= '0;
                        cnt   <= '0;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q <= bcd_nxt;
                    bin_q <= bin_q << 1;
                    cnt   <= cnt + 1'b1;
                    // Last step: publish the finished conversion directly from the next-state value.
                    if (cnt == CW'(RW - 1)) begin
                        oRESULT <= acc;
                        oNEG    <= neg_q;
                        oBCD    <= bcd_nxt;
                        oSEG    <= seg_nxt;
                        oBUSY   <= 1'b0;
                        oDONE   <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq (WIDTH=8, DIGITS=5), one blanking and one non-blanking instance.
module tb_calc_seq;

    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0011000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [7:0]  op1;
    logic [7:0]  op2;

    logic        busy, done, neg;
    logic [15:0] result;
    logic [19:0] bcd;
    logic [34:0] seg;

    logic        z_busy, z_done, z_neg;
    logic [15:0] z_result;
    logic [19:0] z_bcd;
    logic [34:0] z_seg;

    int errors = 0;
    int checks = 0;

    calc_seq #(.WIDTH(8), .DIGITS(5), .BLANK_LZ(1)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iOP(op), .iOP1(op1), .iOP2(op2),
        .oBUSY(busy), .oDONE(done), .oRESULT(result), .oNEG(neg), .oBCD(bcd), .oSEG(seg)
    );

    calc_seq #(.WIDTH(8), .DIGITS(5), .BLANK_LZ(0)) dut_nb (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iOP(op), .iOP1(op1), .iOP2(op2),
        .oBUSY(z_busy), .oDONE(z_done), .oRESULT(z_result), .oNEG(z_neg), .oBCD(z_bcd), .oSEG(z_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request, scrambles the inputs after acceptance, and checks the completion.
    // lat counts rising edges from the accepting edge to the edge that raises oDONE.
    task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input logic [15:0] r, input logic n,
                          input logic [19:0] d, input logic [34:0] s);
        int cyc;
        @(negedge clk);
        op = o; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o; op1 = ~a; op2 = 8'h5A;
        check({name, ".busy"}, 64'(busy), 64'(1));
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            if (!done) cyc++;
        end
        check({name, ".lat"}, 64'(cyc), 64'(lat));
        check({name, ".result"}, 64'(result), 64'(r));
        check({name, ".neg"}, 64'(neg), 64'(n));
        check({name, ".bcd"}, 64'(bcd), 64'(d));
        check({name, ".seg"}, 64'(seg), 64'(s));
        check({name, ".busy_done"}, 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check({name, ".pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int dones;
        logic [15:0] res_cap;
        logic [19:0] bcd_cap;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; op1 = '0; op2 = '0;
        #12;
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.result", 64'(result), 64'(0));
        check("rst.bcd", 64'(bcd), 64'(0));
        check("rst.seg", 64'(seg), 64'({SB, SB, SB, SB, S0}));
        check("rst.seg_nb", 64'(z_seg), 64'({S0, S0, S0, S0, S0}));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", 2'b00, 8'd200, 8'd100, 17, 16'd300, 1'b0, 20'h00300, {SB, SB, S3, S0, S0});
        run_op("sub_neg", 2'b01, 8'd3, 8'd5, 17, 16'd2, 1'b1, 20'h00002, {SB, SB, SB, SB, S2});
        run_op("sub_pos", 2'b01, 8'd5, 8'd3, 17, 16'd2, 1'b0, 20'h00002, {SB, SB, SB, SB, S2});
        run_op("sub_eq", 2'b01, 8'd7, 8'd7, 17, 16'd0, 1'b0, 20'h00000, {SB, SB, SB, SB, S0});
        run_op("sub_neg2", 2'b01, 8'd0, 8'd1, 17, 16'd1, 1'b1, 20'h00001, {SB, SB, SB, SB, S1});
        run_op("mul", 2'b10, 8'd255, 8'd255, 24, 16'd65025, 1'b0, 20'h65025, {S6, S5, S0, S2, S5});

        // A second start during a multiply must be dropped.
        @(negedge clk);
        op = 2'b10; op1 = 8'd12; op2 = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        op = 2'b00; op1 = 8'd200; op2 = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; res_cap = '0; bcd_cap = '0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                res_cap = result;
                bcd_cap = bcd;
            end
        end
        check("ign.dones", 64'(dones), 64'(1));
        check("ign.result", 64'(res_cap), 64'(156));
        check("ign.bcd", 64'(bcd_cap), 64'(20'h00156));

        // Reset in the middle of converting 13*11.
        @(negedge clk);
        op = 2'b10; op1 = 8'd13; op2 = 8'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.busy", 64'(busy), 64'(0));
        check("arst.done", 64'(done), 64'(0));
        check("arst.result", 64'(result), 64'(0));
        check("arst.bcd", 64'(bcd), 64'(0));
        check("arst.seg", 64'(seg), 64'({SB, SB, SB, SB, S0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("arst.no_done", 64'(dones), 64'(0));
        run_op("post_rst", 2'b00, 8'd1, 8'd1, 17, 16'd2, 1'b0, 20'h00002, {SB, SB, SB, SB, S2});

        // Reserved op behaves as add; the non-blanking instance shows every digit.
        run_op("rsv", 2'b11, 8'd9, 8'd0, 17, 16'd9, 1'b0, 20'h00009, {SB, SB, SB, SB, S9});
        check("nb.result", 64'(z_result), 64'(9));
        check("nb.neg", 64'(z_neg), 64'(0));
        check("nb.seg", 64'(z_seg), 64'({S0, S0, S0, S0, S9}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
Sequential, parametrised successor to the team's 3-bit combinational calculator. It accepts two WIDTH-bit unsigned operands and an op code on a start pulse, and computes add, subtract or multiply; multiply uses an iterative shift-add datapath. The result is converted to BCD with a bit-serial double-dabble engine and driven onto DIGITS active-low 7-segment displays, with optional leading-zero blanking. It sits between the board switches/keys and the HEX displays.

Parameters:
WIDTH, 8, operand width in bits (2..16); result width RW = 2*WIDTH
DIGITS, 5, number of decimal digits/displays; must satisfy 10^DIGITS > 2^RW-1 (checked by elaboration assertion)
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is always lit); 0 = show all digits

Ports:
iCLK  in  1  system clock; all state on rising edge
iRST_N  in  1  asynchronous active-low reset
iSTART  in  1  one-cycle request; sampled only in IDLE
iOP  in  2  00 add, 01 subtract, 10 multiply, 11 reserved (treated as add)
iOP1  in  WIDTH  operand A, captured on accepted iSTART
iOP2  in  WIDTH  operand B, captured on accepted iSTART
oBUSY  out  1  high from the cycle after acceptance until oDONE
oDONE  out  1  one-cycle pulse: result, BCD and segments valid
oRESULT  out  RW  binary magnitude of last result
oNEG  out  1  last subtraction had iOP1 < iOP2
oBCD  out  4*DIGITS  packed BCD; digit 0 in bits [3:0]
oSEG  out  7*DIGITS  packed active-low segments, digit 0 in bits [6:0], bit order gfedcba

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; oBUSY=0, oDONE=0, oRESULT=0, oNEG=0, oBCD=0. oSEG: digit 0 = 7'b1000000; other digits = 7'b1111111 if BLANK_LZ, else 7'b1000000. Any operation in flight is discarded.
- States: IDLE, ARITH, CONV, DONE.
- IDLE: iSTART=1 captures iOP/iOP1/iOP2 -> ARITH. iSTART=0 stays in IDLE.
- ARITH, add/sub/reserved: 1 cycle. Sum is zero-extended to RW. Subtract gives |A-B| with oNEG=A<B; A==B gives 0 with oNEG=0.
- ARITH, multiply: exactly WIDTH cycles, one multiplier bit per cycle, LSB first; accumulator RW bits; no overflow is possible.
- CONV: exactly RW cycles of double-dabble. Each cycle: add 3 to every BCD nibble >=5, then shift left one bit taking the result MSB in.
- DONE: 1 cycle. oDONE=1 and oBUSY=0; oRESULT/oNEG/oBCD/oSEG update on the edge entering DONE; then -> IDLE. oNEG is cleared for non-subtract ops.
- Latency: iSTART accepted at edge k gives oDONE high in cycle k+A+RW+1, where A=1 (add/sub) or WIDTH (mul). A new iSTART may be accepted in the cycle after DONE.
- iSTART while not IDLE is ignored (no queueing). Inputs changing after acceptance have no effect.
- Outputs hold their last values between operations.
- Blanking (BLANK_LZ=1): digit i>0 is blanked iff it and all higher digits are 0.
- Segment map is the team-standard active-low hex LUT; BCD only produces 0-9.

Decomposition:
- Package calc_pkg: op-code localparams (OP_ADD, OP_SUB, OP_MUL), FSM state typedef, SEG_BLANK / SEG_ZERO constants.
- Sub-module seg7_lut (4-bit digit in, 7-bit active-low segments out, purely combinational), instantiated DIGITS times by generate.
- Double-dabble and multiplier stay inline in calc_seq.

Test Plan:
- WIDTH=8: reset, then 200+100 -> oDONE at k+18, oRESULT=300, oBCD=0x00300, oSEG digits 2..0 = 0110000/1000000/1000000, digits 4..3 blank.
- Subtract 3-5 -> oRESULT=2, oNEG=1. Then 5-3 -> oRESULT=2, oNEG=0. Then 7-7 -> oRESULT=0, oNEG=0, digit 0 = 1000000, rest blank.
- Multiply 255*255 -> oDONE exactly at k+25, oRESULT=65025, oBCD=0x65025, digit 4 = 0000010.
- iSTART pulsed mid-multiply with different operands -> ignored; exactly one oDONE, result of the first request.
- iRST_N low during CONV of 13*11 -> outputs immediately at reset values, no oDONE. Next request 1+1 -> oRESULT=2.
- BLANK_LZ=0, op 11 with 9+0 -> oRESULT=9, digits 4..1 = 1000000, digit 0 = 0011000.
